// File: rtl/fir_ctrl_pkg.sv
// Shared types and sizing helpers for the FIR stream controller.
// Imported by the controller top and its output FIFO.
package fir_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam int DIN_W_DEF  = 8;
   localparam int DOUT_W_DEF = 16;

   // Width of a counter that must hold values 0..timeout.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous result FIFO; power-of-two depth, so the pointers wrap naturally.
// The head entry is always visible on dout, with no read latency.
module fir_out_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // NOTE: the storage array has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Runs one FIR core iteration per accepted sample, buffers the 16-bit results
// and streams each one out as low byte then high byte, with watchdog and sticky errors.
module fir_stream_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int DIN_W      = DIN_W_DEF,
   parameter int DOUT_W     = DOUT_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [DIN_W-1:0]  s_data,
   output logic              s_ready,
   output logic [DIN_W-1:0]  x_rsc_dat,
   output logic              core_run,
   input  logic              core_complete,
   input  logic [DOUT_W-1:0] y_rsc_dat,
   output logic              m_valid,
   output logic [DIN_W-1:0]  m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   input  logic              clear_err,
   output logic              timeout_err,
   output logic              spurious_err
);

   localparam int CNT_W  = cnt_width(TIMEOUT);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  wait_cnt;
   logic              accept;
   logic              push;
   logic              timeout_hit;
   logic              spurious;
   logic              byte_sel;
   logic              pop;
   logic [DOUT_W-1:0] fifo_dout;
   logic [FCNT_W-1:0] fifo_count;
   logic              fifo_empty;

   assign s_ready  = (state_q == IDLE) && (fifo_count < FCNT_W'(FIFO_DEPTH));
   assign busy     = (state_q != IDLE);
   assign spurious = core_complete && (state_q != WAIT);

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      push        = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (s_valid && s_ready) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN:  state_d = WAIT;
         WAIT: begin
            // Completion on the terminal count still counts as a good result.
            if (core_complete) begin
               push    = 1'b1;
               state_d = IDLE;
            end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         x_rsc_dat    <= '0;
         core_run     <= 1'b0;
         wait_cnt     <= '0;
         byte_sel     <= 1'b0;
         timeout_err  <= 1'b0;
         spurious_err <= 1'b0;
      end else begin
         state_q  <= state_d;
         core_run <= accept;
         if (accept) x_rsc_dat <= s_data;
         if (state_q == RUN)       wait_cnt <= '0;
         else if (state_q == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
         if (m_valid && m_ready)   byte_sel <= ~byte_sel;
         // A new error event outranks a simultaneous clear.
         if (timeout_hit)    timeout_err <= 1'b1;
         else if (clear_err) timeout_err <= 1'b0;
         if (spurious)       spurious_err <= 1'b1;
         else if (clear_err) spurious_err <= 1'b0;
      end
   end

   assign m_valid = !fifo_empty;
   assign m_last  = byte_sel;
   assign m_data  = byte_sel ? fifo_dout[DOUT_W-1:DIN_W] : fifo_dout[DIN_W-1:0];
   assign pop     = m_valid && m_ready && byte_sel;

   fir_out_fifo #(
      .WIDTH (DOUT_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (FCNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (y_rsc_dat),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty)
   );

endmodule
